// File: rtl/br_flow_demux_select.sv
// br_flow_demux_select
//
// Steers a single push flow to one of NumFlows registered pop flows. The
// destination is chosen by a binary select index. Each pop flow has one output
// register stage, so a push appears on its pop flow one cycle after it is
// accepted. A pop transfer and a push transfer can happen on the same flow in
// the same cycle, which sustains one transfer per cycle.
//
// Parameters:
//   NumFlows                       number of pop flows (>= 2)
//   Width                          payload width in bits (>= 1)
//   EnableCoverPushBackpressure    1: cover push backpressure; 0: assert no backpressure
//   EnableAssertPushValidStability 1: push_valid must hold while backpressured
//   EnableAssertPushDataStability  1: push_data must hold while backpressured
//   EnableAssertSelectStability    1: select must hold while backpressured; 0: cover changes
//   EnableAssertPushDataKnown      1: push_data must be known while push_valid
//   EnableAssertFinalNotValid      1: all pop flows must be empty at end of simulation
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   select      binary index of the destination pop flow
//   push_ready  push handshake ready (combinational)
//   push_valid  push handshake valid
//   push_data   push payload
//   pop_ready   per-flow pop ready
//   pop_valid   per-flow pop valid (registered)
//   pop_data    per-flow pop payload, flow i in bits [i*Width +: Width] (registered)

module br_flow_demux_select #(
  parameter int NumFlows                       = 2,
  parameter int Width                          = 1,
  parameter int EnableCoverPushBackpressure    = 1,
  parameter int EnableAssertPushValidStability = EnableCoverPushBackpressure,
  parameter int EnableAssertPushDataStability  = EnableAssertPushValidStability,
  parameter int EnableAssertSelectStability    = 0,
  parameter int EnableAssertPushDataKnown      = 1,
  parameter int EnableAssertFinalNotValid      = 1,
  localparam int SelWidth                      = $clog2(NumFlows)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SelWidth-1:0]       select,
  output logic                      push_ready,
  input  logic                      push_valid,
  input  logic [Width-1:0]          push_data,
  input  logic [NumFlows-1:0]       pop_ready,
  output logic [NumFlows-1:0]       pop_valid,
  output logic [NumFlows*Width-1:0] pop_data
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (NumFlows < 2) begin : gen_bad_num_flows
    $fatal(1, "br_flow_demux_select: NumFlows must be at least 2");
  end
  if (Width < 1) begin : gen_bad_width
    $fatal(1, "br_flow_demux_select: Width must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Pop flow registers
  // ---------------------------------------------------------------------------
  logic [NumFlows-1:0]            valid_q, valid_d;
  logic [NumFlows-1:0][Width-1:0] data_q, data_d;

  // ---------------------------------------------------------------------------
  // Select decode
  // ---------------------------------------------------------------------------
  // The one-hot decode covers only legal indices, so an out-of-range select
  // (possible when NumFlows is not a power of two) decodes to all zeros and
  // therefore reads as an empty, not-ready destination.
  logic [NumFlows-1:0] sel_onehot;
  logic                sel_valid;
  logic                sel_pop_ready;
  logic                select_in_range;
  logic                range_violation;

  always_comb begin
    sel_onehot    = '0;
    sel_valid     = 1'b0;
    sel_pop_ready = 1'b0;
    for (int i = 0; i < NumFlows; i++) begin
      if (select == SelWidth'(i)) begin
        sel_onehot[i] = 1'b1;
        sel_valid     = valid_q[i];
        sel_pop_ready = pop_ready[i];
      end
    end
  end

  assign select_in_range = |sel_onehot;
  assign range_violation = push_valid & ~select_in_range;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  // The selected stage can take new data when it is empty or being drained
  // this cycle. Reset does not gate this; the stage contents are simply
  // discarded by the register update below.
  assign push_ready = select_in_range & (~sel_valid | sel_pop_ready);

  logic                push_xfer;
  logic [NumFlows-1:0] push_xfer_flow;
  logic [NumFlows-1:0] pop_xfer_flow;

  assign push_xfer      = push_valid & push_ready;
  assign push_xfer_flow = sel_onehot & {NumFlows{push_xfer}};
  assign pop_xfer_flow  = valid_q & pop_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // A push into a flow wins over a pop on the same flow: the stage stays full
  // and takes the new payload, so back-to-back traffic has no bubbles.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int i = 0; i < NumFlows; i++) begin
      if (push_xfer_flow[i]) begin
        valid_d[i] = 1'b1;
        data_d[i]  = push_data;
      end else if (pop_xfer_flow[i]) begin
        valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pop_valid = valid_q;
  assign pop_data  = data_q;

  // ---------------------------------------------------------------------------
  // Assertions and covers
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  if (EnableCoverPushBackpressure != 0) begin : gen_cov_push_bp
    cov_push_backpressure : cover property (@(posedge clk) disable iff (rst)
      push_valid && !push_ready);
  end else begin : gen_asrt_no_push_bp
    asrt_no_push_backpressure : assert property (@(posedge clk) disable iff (rst)
      push_valid |-> push_ready)
      else $error("br_flow_demux_select: push backpressure not allowed");
  end

  if (EnableAssertPushValidStability != 0) begin : gen_asrt_valid_stable
    asrt_push_valid_stable : assert property (@(posedge clk) disable iff (rst)
      (push_valid && !push_ready) |=> push_valid)
      else $error("br_flow_demux_select: push_valid dropped while backpressured");
  end

  if (EnableAssertPushDataStability != 0) begin : gen_asrt_data_stable
    asrt_push_data_stable : assert property (@(posedge clk) disable iff (rst)
      (push_valid && !push_ready) |=> $stable(push_data))
      else $error("br_flow_demux_select: push_data changed while backpressured");
  end

  if (EnableAssertSelectStability != 0) begin : gen_asrt_select_stable
    asrt_select_stable : assert property (@(posedge clk) disable iff (rst)
      (push_valid && !push_ready) |=> $stable(select))
      else $error("br_flow_demux_select: select changed while backpressured");
  end else begin : gen_cov_select_change
    cov_select_change : cover property (@(posedge clk) disable iff (rst)
      (push_valid && !push_ready) ##1 (select != $past(select)));
  end

  if (EnableAssertPushDataKnown != 0) begin : gen_asrt_data_known
    asrt_push_data_known : assert property (@(posedge clk) disable iff (rst)
      push_valid |-> !$isunknown(push_data))
      else $error("br_flow_demux_select: push_data unknown while push_valid");
  end

  // Reported as a warning so the event is visible without stopping a run.
  asrt_select_in_range : assert property (@(posedge clk) disable iff (rst)
    !range_violation)
    else $warning("br_flow_demux_select: push_valid with select out of range");

  for (genvar i = 0; i < NumFlows; i++) begin : gen_flow_covers
    cov_push_xfer : cover property (@(posedge clk) disable iff (rst)
      push_xfer_flow[i]);
    cov_push_pop_xfer : cover property (@(posedge clk) disable iff (rst)
      push_xfer_flow[i] && pop_xfer_flow[i]);
  end

  if (EnableAssertFinalNotValid != 0) begin : gen_asrt_final
    final begin
      asrt_final_not_valid : assert (valid_q == '0)
        else $error("br_flow_demux_select: pop_valid set at end of simulation");
    end
  end
`endif

endmodule

// File: tb/tb_br_flow_demux_select.sv
// Bench for br_flow_demux_select. A NumFlows=4 / Width=8 instance runs a table
// of single-cycle vectors plus streaming and reset sequences; a NumFlows=3
// instance exercises the out-of-range select.

module tb_br_flow_demux_select;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // NumFlows=4 instance
  logic [1:0]  sel4;
  logic        pv4;
  logic [7:0]  pd4;
  logic [3:0]  pr4;
  logic        ready4;
  logic [3:0]  valid4;
  logic [31:0] data4;

  // NumFlows=3 instance
  logic [1:0]  sel3;
  logic        pv3;
  logic [7:0]  pd3;
  logic [2:0]  pr3;
  logic        ready3;
  logic [2:0]  valid3;
  logic [23:0] data3;

  br_flow_demux_select #(
    .NumFlows(4),
    .Width   (8)
  ) dut4 (
    .clk       (clk),
    .rst       (rst),
    .select    (sel4),
    .push_ready(ready4),
    .push_valid(pv4),
    .push_data (pd4),
    .pop_ready (pr4),
    .pop_valid (valid4),
    .pop_data  (data4)
  );

  br_flow_demux_select #(
    .NumFlows                      (3),
    .Width                         (8),
    .EnableAssertPushValidStability(0),
    .EnableAssertPushDataStability (0)
  ) dut3 (
    .clk       (clk),
    .rst       (rst),
    .select    (sel3),
    .push_ready(ready3),
    .push_valid(pv3),
    .push_data (pd3),
    .pop_ready (pr3),
    .pop_valid (valid3),
    .pop_data  (data3)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  sel;
    logic        pv;
    logic [7:0]  pd;
    logic [3:0]  pr;
    logic        exp_ready;   // push_ready before the edge
    logic [3:0]  exp_valid;   // pop_valid after the edge
    logic [31:0] exp_data;    // pop_data after the edge
  } vec_t;

  vec_t vecs[14];

  initial begin
    // rst sel pv pd pr | ready valid data
    vecs[0]  = '{1'b1, 2'd0, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h0000_0000};
    // push during reset is discarded
    vecs[1]  = '{1'b1, 2'd2, 1'b1, 8'h5A, 4'b1111, 1'b1, 4'b0000, 32'h0000_0000};
    // basic push to flow 2, then it drains
    vecs[2]  = '{1'b0, 2'd2, 1'b1, 8'hA5, 4'b1111, 1'b1, 4'b0100, 32'h00A5_0000};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h00A5_0000};
    // flow 1 backpressured: 0x11 held, 0x22 waits
    vecs[4]  = '{1'b0, 2'd1, 1'b1, 8'h11, 4'b1101, 1'b1, 4'b0010, 32'h00A5_1100};
    vecs[5]  = '{1'b0, 2'd1, 1'b1, 8'h22, 4'b1101, 1'b0, 4'b0010, 32'h00A5_1100};
    vecs[6]  = '{1'b0, 2'd1, 1'b1, 8'h22, 4'b1101, 1'b0, 4'b0010, 32'h00A5_1100};
    // release: simultaneous pop and push on flow 1
    vecs[7]  = '{1'b0, 2'd1, 1'b1, 8'h22, 4'b1111, 1'b1, 4'b0010, 32'h00A5_2200};
    vecs[8]  = '{1'b0, 2'd1, 1'b0, 8'h00, 4'b1101, 1'b0, 4'b0010, 32'h00A5_2200};
    // flow 3 independent of full flow 1
    vecs[9]  = '{1'b0, 2'd3, 1'b1, 8'h33, 4'b1101, 1'b1, 4'b1010, 32'h33A5_2200};
    vecs[10] = '{1'b0, 2'd3, 1'b0, 8'h00, 4'b0000, 1'b0, 4'b1010, 32'h33A5_2200};
    vecs[11] = '{1'b0, 2'd0, 1'b1, 8'h77, 4'b0111, 1'b1, 4'b1001, 32'h33A5_2277};
    // mid-operation reset drops everything
    vecs[12] = '{1'b1, 2'd0, 1'b0, 8'h00, 4'b0000, 1'b0, 4'b0000, 32'h0000_0000};
    vecs[13] = '{1'b0, 2'd0, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h0000_0000};

    rst  = 1'b1;
    sel4 = '0; pv4 = 1'b0; pd4 = '0; pr4 = '1;
    sel3 = '0; pv3 = 1'b0; pd3 = '0; pr3 = '1;
    tick();

    for (int i = 0; i < 14; i++) begin
      rst  = vecs[i].rst;
      sel4 = vecs[i].sel;
      pv4  = vecs[i].pv;
      pd4  = vecs[i].pd;
      pr4  = vecs[i].pr;
      #1;
      check($sformatf("vec%0d push_ready", i), 32'(ready4), 32'(vecs[i].exp_ready));
      tick();
      check($sformatf("vec%0d pop_valid", i), 32'(valid4), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d pop_data", i), data4, vecs[i].exp_data);
    end

    // Streaming on flow 0: one transfer per cycle, in order, no bubbles
    rst = 1'b0; sel4 = 2'd0; pr4 = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      pv4 = 1'b1;
      pd4 = 8'(k);
      #1;
      check($sformatf("stream%0d push_ready", k), 32'(ready4), 32'd1);
      tick();
      check($sformatf("stream%0d pop_valid", k), 32'(valid4), 32'b0001);
      check($sformatf("stream%0d pop_data0", k), 32'(data4[7:0]), 32'(k));
    end
    pv4 = 1'b0; pd4 = '0; pr4 = 4'b1111;
    tick();
    check("stream drained", 32'(valid4), 32'd0);

    // Flows 0 and 2 full, one-cycle reset pulse, then a fresh push to flow 2
    sel4 = 2'd0; pv4 = 1'b1; pd4 = 8'hC0; pr4 = 4'b0000;
    tick();
    sel4 = 2'd2; pd4 = 8'hC2;
    #1;
    check("fill2 push_ready", 32'(ready4), 32'd1);
    tick();
    check("fill pop_valid", 32'(valid4), 32'b0101);
    check("fill pop_data", data4, 32'h00C2_00C0);
    pv4 = 1'b0; pd4 = '0; rst = 1'b1;
    tick();
    check("rst pulse pop_valid", 32'(valid4), 32'd0);
    check("rst pulse pop_data", data4, 32'd0);
    rst = 1'b0; sel4 = 2'd2; pv4 = 1'b1; pd4 = 8'hD2; pr4 = 4'b1111;
    tick();
    check("post rst pop_valid", 32'(valid4), 32'b0100);
    check("post rst pop_data", data4, 32'h00D2_0000);
    pv4 = 1'b0; pd4 = '0;
    tick();
    check("post rst drained", 32'(valid4), 32'd0);

    // NumFlows=3: select=3 is out of range
    sel3 = 2'd0; pv3 = 1'b1; pd3 = 8'h10; pr3 = 3'b000;
    tick();
    check("n3 prefill pop_valid", 32'(valid3), 32'b001);
    sel3 = 2'd3; pd3 = 8'h55;
    #1;
    check("n3 oob push_ready", 32'(ready3), 32'd0);
    check("n3 oob range flag", 32'(dut3.range_violation), 32'd1);
    tick();
    check("n3 oob pop_valid", 32'(valid3), 32'b001);
    check("n3 oob pop_data", 32'(data3), 32'h00_0010);
    sel3 = 2'd0; pv3 = 1'b0; pd3 = '0; pr3 = 3'b111;
    tick();
    check("n3 drained", 32'(valid3), 32'd0);

    tick();
    check("final dut4 empty", 32'(valid4), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/br_flow_demux_select.md
BR_FLOW_DEMUX_SELECT -- requirements
Module: br_flow_demux_select

Interface
REQ-001 The block SHALL provide parameter NumFlows, default 2, meaning the number of pop flows; a value below 2 is a fatal elaboration error.
REQ-002 The block SHALL provide parameter Width, default 1, meaning the payload width in bits; a value below 1 is a fatal elaboration error.
REQ-003 The block SHALL provide parameter EnableCoverPushBackpressure, default 1, meaning: 1 covers push backpressure; 0 asserts push_valid implies push_ready.
REQ-004 The block SHALL provide parameter EnableAssertPushValidStability, default EnableCoverPushBackpressure, meaning: 1 asserts push_valid holds while backpressured.
REQ-005 The block SHALL provide parameter EnableAssertPushDataStability, default EnableAssertPushValidStability, meaning: 1 asserts push_data holds while backpressured.
REQ-006 The block SHALL provide parameter EnableAssertSelectStability, default 0, meaning: 1 asserts select holds while push_valid is 1 and push_ready is 0; 0 covers select changing in that state.
REQ-007 The block SHALL provide parameter EnableAssertPushDataKnown, default 1, meaning: 1 asserts push_data is not X when push_valid is 1.
REQ-008 The block SHALL provide parameter EnableAssertFinalNotValid, default 1, meaning: 1 asserts every pop_valid bit is 0 at end of test.
REQ-009 The block SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-010 The block SHALL provide port rst, input, 1 bit: reset, synchronous and active-high.
REQ-011 The block SHALL provide port select, input, $clog2(NumFlows) bits: binary index of the destination pop flow.
REQ-012 The block SHALL provide port push_ready, output, 1 bit, and ports push_valid, input, 1 bit, and push_data, input, Width bits, forming the single push handshake.
REQ-013 The block SHALL provide port pop_ready, input, NumFlows bits, and ports pop_valid, output, NumFlows bits, and pop_data, output, NumFlows x Width bits, forming per-flow pop handshakes.

Function
REQ-014 A transfer SHALL occur on any cycle where push_valid and push_ready are both 1; pop flow i SHALL transfer on any cycle where pop_valid[i] and pop_ready[i] are both 1.
REQ-015 Each pop flow SHALL have one output register stage: a valid bit and a Width-bit data register, driving pop_valid[i] and pop_data[i] directly from flops.
REQ-016 push_ready SHALL equal (select < NumFlows) AND (NOT pop_valid[select] OR pop_ready[select]), combinationally.
REQ-017 On a push transfer with select = s, the next cycle SHALL have pop_valid[s] = 1 and pop_data[s] = the accepted push_data, giving one-cycle latency.
REQ-018 With no push transfer to flow i, a pop transfer on flow i SHALL clear pop_valid[i] next cycle.
REQ-019 With neither a push nor a pop transfer on flow i, pop_valid[i] and pop_data[i] SHALL hold.
REQ-020 A simultaneous pop transfer and push transfer on the same flow SHALL leave pop_valid[i] = 1 with the new data, sustaining one transfer per cycle.
REQ-021 Flows not equal to select SHALL be unaffected by push activity, and their pop handshakes SHALL proceed independently every cycle.
REQ-022 pop_valid[i] SHALL be 1 with pop_ready[i] = 0 until a pop transfer occurs; pop_data[i] SHALL be held in that state.
REQ-023 If NumFlows is not a power of two and select >= NumFlows, push_ready SHALL be 0, no state SHALL change, and an assertion SHALL fire if push_valid is 1.
REQ-024 The enabled assertions and covers of REQ-003 to REQ-008 SHALL be implemented; covers SHALL include a push transfer per flow and a simultaneous push/pop transfer per flow.

Reset
REQ-025 While rst is 1, every pop_valid bit SHALL be 0 on the following cycle and every pop_data register SHALL be 0.
REQ-026 push_ready SHALL follow REQ-016 during reset; it evaluates to 1 for an in-range select because all pop_valid bits are 0.
REQ-027 A transfer in the cycle rst is asserted SHALL be discarded.
REQ-028 Reset asserted mid-operation SHALL drop all held entries and leave no residue.

Verification
REQ-029 The bench SHALL cover: NumFlows=4, Width=8, after reset push 0xA5 with select=2 and pop_ready=4'b1111 -> next cycle pop_valid=4'b0100, pop_data[2]=0xA5; the cycle after, pop_valid=0.
REQ-030 The bench SHALL cover: pop_ready[1]=0; push 0x11 then 0x22, both with select=1 -> 0x11 is held on pop_data[1]; push_ready=0 while select=1; after pop_ready[1]=1, 0x22 appears the next cycle.
REQ-031 The bench SHALL cover: pop_ready[1]=0 holding flow 1 full; select=3, push 0x33 -> push_ready=1 and pop_valid[3]=1 next cycle, independent of flow 1.
REQ-032 The bench SHALL cover: pop_ready[0]=1 and select=0 with push every cycle of 0x01..0x08 -> eight consecutive pop transfers on flow 0 with no bubbles, in order.
REQ-033 The bench SHALL cover: NumFlows=3, push_valid=1 with select=3 -> push_ready=0, no pop_valid changes, and the range assertion fires.
REQ-034 The bench SHALL cover: flows 0 and 2 holding data with rst pulsed for one cycle -> pop_valid=0 on the following cycle and pop_data all 0; the next push to flow 2 emerges after one cycle.
